// File: rtl/fsqrt_iter.sv
// Multi-cycle binary32 sqrt / rsqrt: one Newton-Raphson reciprocal-square-root step per clock
// on a single fixed-point datapath, with valid/ready handshakes on both sides.
module fsqrt_iter #(
  parameter int unsigned ITER = 5,
  parameter int unsigned FRAC = 28
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  localparam int unsigned F  = FRAC - 2;
  localparam int unsigned PW = 2 * FRAC;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFinal, StDone} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            x_q, x_d, y_q, y_d;
  logic                   mode_q, mode_d, ov_q, ov_d, spec_q, spec_d;
  logic [FRAC-1:0]        a_q, a_d, est_q, est_d;
  logic signed [9:0]      h_q, h_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Operand classification and normalisation
  logic                   sgn, is_nan, special;
  logic [7:0]             ex;
  logic [22:0]            man;
  logic [4:0]             lead_m;
  logic [23:0]            sig;
  logic signed [9:0]      e_unb;
  logic [FRAC-1:0]        a_prep;
  logic [31:0]            spec_y;

  always_comb begin
    sgn    = x_q[31];
    ex     = x_q[30:23];
    man    = x_q[22:0];
    lead_m = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (man[i]) lead_m = 5'(i);
    end
    if (ex == 8'd0) begin
      sig   = {1'b0, man} << (5'd23 - lead_m);
      e_unb = $signed({5'd0, lead_m}) - 10'sd149;
    end else begin
      sig   = {1'b1, man};
      e_unb = $signed({2'b00, ex}) - 10'sd127;
    end
    // Odd exponent folds one factor of two into the mantissa so a lies in [1,4)
    a_prep = e_unb[0] ? (FRAC'(sig) << (F - 22)) : (FRAC'(sig) << (F - 23));

    is_nan  = (ex == 8'hFF) && (man != 23'd0);
    special = 1'b1;
    if (is_nan)                                spec_y = {sgn, 8'hFF, 1'b1, man[21:0]};
    else if (sgn && (ex != 8'd0 || man != 23'd0)) spec_y = 32'hFFC0_0000;
    else if (ex == 8'hFF)                      spec_y = mode_q ? 32'h0000_0000 : 32'h7F80_0000;
    else if (ex == 8'd0 && man == 23'd0)       spec_y = mode_q ? {sgn, 8'hFF, 23'd0} : {sgn, 31'd0};
    else begin
      special = 1'b0;
      spec_y  = 32'd0;
    end
  end

  // Shared Newton datapath; the second multiplier forms a*y in FINAL
  logic [PW-1:0]   sq_full, prod2, p3;
  logic [FRAC-1:0] sq_r, mul_b, t_r, h3, est_nxt;

  always_comb begin
    sq_full = PW'(est_q) * PW'(est_q);
    sq_r    = sq_full[F +: FRAC] + FRAC'(sq_full[F-1]);
    mul_b   = (state_q == StFinal) ? est_q : sq_r;
    prod2   = PW'(a_q) * PW'(mul_b);
    t_r     = prod2[F +: FRAC] + FRAC'(prod2[F-1]);
    h3      = (FRAC'(3) << F) - t_r;
    p3      = PW'(est_q) * PW'(h3);
    est_nxt = p3[F+1 +: FRAC] + FRAC'(p3[F]);
  end

  // Final normalisation and round-to-nearest-even
  logic [PW-1:0] v, norm;
  logic [6:0]    lead_v;
  logic [23:0]   mant;
  logic          guard, sticky, rnd;
  logic [24:0]   mant_r;
  logic [11:0]   h_ext, exp_r;
  logic [31:0]   y_fin;

  always_comb begin
    v      = mode_q ? (PW'(est_q) << F) : prod2;
    lead_v = 7'd0;
    for (int i = 0; i < PW; i++) begin
      if (v[i]) lead_v = 7'(i);
    end
    norm   = v << (7'(PW - 1) - lead_v);
    mant   = norm[PW-1 -: 24];
    guard  = norm[PW-25];
    sticky = |norm[PW-26:0];
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + 25'(rnd);
    h_ext  = {{2{h_q[9]}}, h_q};
    exp_r  = 12'd127 + (mode_q ? (12'd0 - h_ext) : h_ext) + 12'(lead_v) - 12'(2 * F)
             + 12'(mant_r[24]);
    y_fin  = {1'b0, exp_r[7:0], mant_r[24] ? 23'd0 : mant_r[22:0]};
  end

  logic unused_bits;
  assign unused_bits = ^{sq_full[F-2:0], sq_full[PW-1:F+FRAC], p3[F-1:0], p3[PW-1],
                         exp_r[11:8], mant_r[23]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    a_d     = a_q;
    h_d     = h_q;
    est_d   = est_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ov_d    = ov_q;
    spec_d  = spec_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          mode_d  = mode;
          state_d = StPrep;
        end
      end
      StPrep: begin
        a_d    = a_prep;
        h_d    = e_unb >>> 1;
        est_d  = FRAC'(3) << (F - 2);
        cnt_d  = '0;
        spec_d = special;
        if (special) y_d = spec_y;
        // Specials still pass through FINAL so their latency is fixed at two cycles
        state_d = special ? StFinal : StIter;
      end
      StIter: begin
        est_d = est_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = StFinal;
      end
      StFinal: begin
        if (!spec_q) y_d = y_fin;
        ov_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      x_q     <= 32'd0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      h_q     <= '0;
      est_q   <= '0;
      cnt_q   <= '0;
      y_q     <= 32'd0;
      ov_q    <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      h_q     <= h_d;
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      spec_q  <= spec_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = ov_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Directed bench for fsqrt_iter: ITER=5 and ITER=8 instances, results checked against
// hand-computed binary32 values with immediate assertions.
module tb_fsqrt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, mode, out_ready, sel;
  logic [31:0] x;
  logic        in_ready5, out_valid5, busy5, in_ready8, out_valid8, busy8;
  logic [31:0] y5, y8;
  logic        in_ready, out_valid, busy;
  logic [31:0] y;

  int n_pass = 0;
  int n_total = 0;

  fsqrt_iter #(.ITER(5), .FRAC(28)) dut5 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid & ~sel), .in_ready(in_ready5), .x(x),
    .mode(mode), .out_valid(out_valid5), .out_ready(out_ready), .y(y5), .busy(busy5)
  );

  fsqrt_iter #(.ITER(8), .FRAC(28)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid & sel), .in_ready(in_ready8), .x(x),
    .mode(mode), .out_valid(out_valid8), .out_ready(out_ready), .y(y8), .busy(busy8)
  );

  assign in_ready  = sel ? in_ready8  : in_ready5;
  assign out_valid = sel ? out_valid8 : out_valid5;
  assign busy      = sel ? busy8      : busy5;
  assign y         = sel ? y8         : y5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic ok;
    ok = (obs >= exp - 32'd1) && (obs <= exp + 32'd1);
    n_total++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s: got %h, expected %h +/-1 ulp", tag, obs, exp);
  endtask

  // Issue one operand with out_ready high, then check latency, result and the one-cycle pulse
  task automatic op_check(input string tag, input logic [31:0] xv, input logic mv,
                          input int lat, input logic [31:0] exp, input int tol);
    int k;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(in_ready), 32'd1);
    x = xv; mode = mv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; x = ~xv; mode = ~mv;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/lat"}, 32'(k), 32'(lat));
    if (tol == 0) chk({tag, "/y"}, y, exp);
    else chk_ulp({tag, "/y"}, y, exp);
    @(negedge clk);
    chk({tag, "/pulse"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  task automatic reset_mid_op(input string tag);
    @(negedge clk);
    x = 32'h4080_0000; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "/busy_iter"}, 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk({tag, "/rst"}, 32'({out_valid, busy, in_ready}), 32'b001);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk({tag, "/no_result"}, 32'({out_valid, busy}), 32'b00);
  endtask

  initial begin
    int k;
    logic [31:0] held;
    logic stable;

    sel = 1'b0; out_ready = 1'b1; mode = 1'b0; x = 32'h4080_0000; in_valid = 1'b1;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    chk("rst/y", y, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rstn = 1'b1;
    @(negedge clk);
    chk("rst/no_capture", 32'(busy), 32'd0);

    op_check("sqrt4", 32'h4080_0000, 1'b0, 7, 32'h4000_0000, 0);
    op_check("rsqrt4", 32'h4080_0000, 1'b1, 7, 32'h3F00_0000, 0);
    op_check("sqrt2", 32'h4000_0000, 1'b0, 7, 32'h3FB5_04F3, 1);
    op_check("sqrt9", 32'h4110_0000, 1'b0, 7, 32'h4040_0000, 0);
    op_check("rsqrt_q", 32'h3E80_0000, 1'b1, 7, 32'h4000_0000, 0);
    op_check("rsqrt1", 32'h3F80_0000, 1'b1, 7, 32'h3F80_0000, 0);

    op_check("nan", 32'h7FA0_0001, 1'b0, 2, 32'h7FE0_0001, 0);
    op_check("neg", 32'hC000_0000, 1'b1, 2, 32'hFFC0_0000, 0);
    op_check("neginf", 32'hFF80_0000, 1'b0, 2, 32'hFFC0_0000, 0);
    op_check("nzero_s", 32'h8000_0000, 1'b0, 2, 32'h8000_0000, 0);
    op_check("nzero_r", 32'h8000_0000, 1'b1, 2, 32'hFF80_0000, 0);
    op_check("pinf_r", 32'h7F80_0000, 1'b1, 2, 32'h0000_0000, 0);
    op_check("pzero_r", 32'h0000_0000, 1'b1, 2, 32'h7F80_0000, 0);

    op_check("sub_min", 32'h0000_0001, 1'b0, 7, 32'h1A35_04F3, 1);
    op_check("sub_min_r", 32'h0000_0001, 1'b1, 7, 32'h64B5_04F3, 1);
    op_check("sub_odd", 32'h0040_0000, 1'b0, 7, 32'h1FB5_04F3, 1);
    op_check("sub_even", 32'h0020_0000, 1'b0, 7, 32'h1F80_0000, 0);

    // Backpressure: a second operand is offered the whole time the first result waits
    out_ready = 1'b0;
    @(negedge clk);
    x = 32'h4080_0000; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    x = 32'h4110_0000;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp/lat", 32'(k), 32'd7);
    held = y;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      stable &= (y === held) && (out_valid === 1'b1) && (in_ready === 1'b0);
    end
    chk("bp/hold", 32'(stable), 32'd1);
    chk("bp/y", held, 32'h4000_0000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp/consumed", 32'({out_valid, in_ready}), 32'b01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp/accept2", 32'(busy), 32'd1);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp/lat2", 32'(k), 32'd7);
    chk("bp/y2", y, 32'h4040_0000);
    @(negedge clk);

    reset_mid_op("rst5");
    op_check("after_rst5", 32'h4110_0000, 1'b0, 7, 32'h4040_0000, 0);

    sel = 1'b1;
    op_check("i8_sqrt4", 32'h4080_0000, 1'b0, 10, 32'h4000_0000, 0);
    reset_mid_op("rst8");
    op_check("i8_rsqrt4", 32'h4080_0000, 1'b1, 10, 32'h3F00_0000, 0);
    op_check("i8_sqrt2", 32'h4000_0000, 1'b0, 10, 32'h3FB5_04F3, 1);
    op_check("i8_nan", 32'h7FA0_0001, 1'b1, 2, 32'h7FE0_0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
